// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - fetch, data and memory bus signals of the memory bus arbiter
interface mem_bus_arbiter_if;
  // fetch port (IF stage)
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready_n;
  // data port (MEM stage)
  logic        d_req;
  logic        d_write;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready_n;
  logic        d_busy;
  // unified memory bus
  logic        m_req;
  logic        m_write;
  logic [1:0]  m_size;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready_n;
  // timeout abort pulse
  logic        err;

  // arbiter view: serves both requesters and masters the memory bus
  modport master (
    input  i_req, i_addr, d_req, d_write, d_size, d_addr, d_wdata, m_rdata, m_ready_n,
    output i_rdata, i_ready_n, d_rdata, d_ready_n, d_busy,
           m_req, m_write, m_size, m_addr, m_wdata, err
  );

  // environment view: pipeline requesters plus the memory itself
  modport slave (
    output i_req, i_addr, d_req, d_write, d_size, d_addr, d_wdata, m_rdata, m_ready_n,
    input  i_rdata, i_ready_n, d_rdata, d_ready_n, d_busy,
           m_req, m_write, m_size, m_addr, m_wdata, err
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - fetch/data arbiter for the unified memory bus; ARB_FAIR_EN adds fetch anti-starvation
module mem_bus_arbiter #(
  parameter int TO_CYCLES = 255,
  parameter int MAX_D_RUN = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2,
    RESP = 2'd3
  } state_t;

  // timeout fires at the end of the TO_CYCLES-th access cycle
  localparam logic [7:0] TO_LAST = 8'(TO_CYCLES - 1);

  if (TO_CYCLES < 1 || TO_CYCLES > 255) begin : g_bad_to_cycles
    $error("mem_bus_arbiter: TO_CYCLES must be in 1..255");
  end
  if (MAX_D_RUN < 1 || MAX_D_RUN > 255) begin : g_bad_max_d_run
    $error("mem_bus_arbiter: MAX_D_RUN must be in 1..255");
  end

  state_t      state_q, state_d;
  logic        owner_d_q, owner_d_d;   // 1: data port owns the bus, 0: fetch port
  logic        err_q, err_d;
  logic        grant_d, grant_i;
  logic        fetch_forced;
  logic        in_access;
  logic [7:0]  to_cnt_q;
  logic [31:0] m_addr_q, m_wdata_q, i_rdata_q, d_rdata_q;
  logic [1:0]  m_size_q;
  logic        m_write_q;

  assign in_access = (state_q == IACC) || (state_q == DACC);

`ifdef ARB_FAIR_EN
  localparam logic [7:0] RUN_MAX = 8'(MAX_D_RUN);
  logic [7:0] run_q;

  assign fetch_forced = bus.i_req && (run_q == RUN_MAX);

  // count back-to-back data grants; saturates so a waiting fetch is always let in
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q <= '0;
    end else if (grant_i) begin
      run_q <= '0;
    end else if (grant_d && (run_q != RUN_MAX)) begin
      run_q <= run_q + 8'd1;
    end
  end
`else
  assign fetch_forced = 1'b0;
`endif

  // next-state: data wins in IDLE (older instruction) unless fairness forces a fetch
  always_comb begin
    state_d   = state_q;
    owner_d_d = owner_d_q;
    err_d     = 1'b0;
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.d_req && !fetch_forced) begin
          grant_d   = 1'b1;
          owner_d_d = 1'b1;
          state_d   = DACC;
        end else if (bus.i_req) begin
          grant_i   = 1'b1;
          owner_d_d = 1'b0;
          state_d   = IACC;
        end
      end
      IACC, DACC: begin
        if (!bus.m_ready_n) begin
          state_d = RESP;
        end else if (to_cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state, owner, abort pulse and per-access timeout counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      owner_d_q <= 1'b0;
      err_q     <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_d_q <= owner_d_d;
      err_q     <= err_d;
      if (grant_d || grant_i) begin
        to_cnt_q <= '0;
      end else if (in_access && bus.m_ready_n) begin
        to_cnt_q <= to_cnt_q + 8'd1;
      end
    end
  end

  // latch the winner's request at grant; capture read data on completion (stores keep d_rdata)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_size_q  <= 2'b00;
      m_write_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (grant_d) begin
        m_addr_q  <= bus.d_addr;
        m_wdata_q <= bus.d_wdata;
        m_size_q  <= bus.d_size;
        m_write_q <= bus.d_write;
      end else if (grant_i) begin
        m_addr_q  <= bus.i_addr;
        m_size_q  <= 2'b10;
        m_write_q <= 1'b0;
      end
      if ((state_q == IACC) && !bus.m_ready_n) begin
        i_rdata_q <= bus.m_rdata;
      end
      if ((state_q == DACC) && !bus.m_ready_n && !m_write_q) begin
        d_rdata_q <= bus.m_rdata;
      end
    end
  end

  // m_req follows the state so an asynchronous reset drops it immediately
  assign bus.m_req     = in_access;
  assign bus.m_write   = m_write_q;
  assign bus.m_size    = m_size_q;
  assign bus.m_addr    = m_addr_q;
  assign bus.m_wdata   = m_wdata_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.i_ready_n = !((state_q == RESP) && !owner_d_q);
  assign bus.d_ready_n = !((state_q == RESP) && owner_d_q);
  assign bus.d_busy    = (state_q == IACC) || ((state_q == RESP) && !owner_d_q);
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
  localparam int TO     = 4;
  localparam int MAXRUN = 4;
`ifdef ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_bus_arbiter_if bus ();

  mem_bus_arbiter #(.TO_CYCLES(TO), .MAX_D_RUN(MAXRUN)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // memory: answers the mem_lat-th cycle of a request; can hang or glitch m_ready_n while idle
  int          mem_lat   = 1;
  bit          mem_hang  = 1'b0;
  bit          mem_stray = 1'b0;
  int          mcnt      = 0;
  logic [31:0] mem_data  = '0;
  initial begin
    bus.m_ready_n = 1'b1;
    bus.m_rdata   = '0;
  end
  always @(posedge clk) begin
    #2;
    if (bus.m_req) begin
      mcnt = mcnt + 1;
      bus.m_ready_n = !((mcnt == mem_lat) && !mem_hang);
    end else begin
      mcnt = 0;
      bus.m_ready_n = !mem_stray;
    end
    bus.m_rdata = mem_data;
  end

  // reference model: who owns the bus, how long, who gets the response
  int          mo_own = 0;    // 0 none, 1 fetch, 2 data
  int          mo_cnt = 0;    // completed cycles of the current access
  int          mo_rown = 0;   // requester receiving its ready pulse this cycle
  int          mo_run = 0;    // data grants since the last fetch grant
  bit          mo_err = 1'b0;
  logic [31:0] mo_addr = '0, mo_wdata = '0, mo_irdata = '0, mo_drdata = '0;
  logic [1:0]  mo_size = '0;
  logic        mo_write = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mo_own <= 0; mo_cnt <= 0; mo_rown <= 0; mo_run <= 0; mo_err <= 1'b0;
      mo_addr <= '0; mo_wdata <= '0; mo_size <= '0; mo_write <= 1'b0;
      mo_irdata <= '0; mo_drdata <= '0;
    end else begin
      mo_err  <= 1'b0;
      mo_rown <= 0;
      if (mo_rown != 0) begin
        // response cycle: bus returns to idle, held requests are not re-served yet
      end else if (mo_own != 0) begin
        if (!bus.m_ready_n) begin
          if (mo_own == 1) mo_irdata <= bus.m_rdata;
          else if (!mo_write) mo_drdata <= bus.m_rdata;
          mo_rown <= mo_own;
          mo_own  <= 0;
        end else if (mo_cnt + 1 >= TO) begin
          mo_err <= 1'b1;
          mo_own <= 0;
        end else begin
          mo_cnt <= mo_cnt + 1;
        end
      end else if (bus.d_req && !(FAIR && bus.i_req && (mo_run >= MAXRUN))) begin
        mo_own <= 2; mo_cnt <= 0;
        mo_addr <= bus.d_addr; mo_wdata <= bus.d_wdata;
        mo_size <= bus.d_size; mo_write <= bus.d_write;
        mo_run <= (mo_run < MAXRUN) ? mo_run + 1 : mo_run;
      end else if (bus.i_req) begin
        mo_own <= 1; mo_cnt <= 0;
        mo_addr <= bus.i_addr; mo_size <= 2'b10; mo_write <= 1'b0;
        mo_run <= 0;
      end
    end
  end

  // per-cycle comparison of every meaningful output against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_req", 32'(bus.m_req), 32'(mo_own != 0));
      if (mo_own != 0) begin
        chk("m_addr", bus.m_addr, mo_addr);
        chk("m_size", 32'(bus.m_size), 32'(mo_size));
        chk("m_write", 32'(bus.m_write), 32'(mo_write));
        if (mo_write) chk("m_wdata", bus.m_wdata, mo_wdata);
      end
      chk("i_ready_n", 32'(bus.i_ready_n), 32'(mo_rown != 1));
      chk("d_ready_n", 32'(bus.d_ready_n), 32'(mo_rown != 2));
      chk("i_rdata", bus.i_rdata, mo_irdata);
      chk("d_rdata", bus.d_rdata, mo_drdata);
      chk("d_busy", 32'(bus.d_busy), 32'((mo_own == 1) || (mo_rown == 1)));
      chk("err", 32'(bus.err), 32'(mo_err));
    end
  end

  // grant log taken from the DUT bus: each m_req burst is one grant, d_busy tells fetch from data
  int glog[$];
  int bursts   = 0;
  bit prev_req = 1'b0;
  always @(negedge clk) begin
    if (bus.m_req && !prev_req) begin
      bursts <= bursts + 1;
      glog.push_back(bus.d_busy ? 1 : 2);
    end
    prev_req <= bus.m_req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy(input bit is_d, input int max, output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 0;
    while (!ok && (cyc < max)) begin
      @(negedge clk);
      cyc++;
      if (is_d ? !bus.d_ready_n : !bus.i_ready_n) ok = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          cyc, acc, b0;
    bit          ok, busy_seen, stable_ok;
    logic [31:0] s_addr;
    logic [1:0]  s_size;
    logic        s_wr;
    int          exp_order[6];

    rst_n = 1'b0;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_write = 1'b0; bus.d_size = 2'b10;
    bus.d_addr = '0; bus.d_wdata = '0;
    repeat (3) @(posedge clk);
    cmp_en = 1'b1;
    #3 rst_n = 1'b1;

    // reset state
    @(negedge clk);
    chk("rst_m_req", 32'(bus.m_req), 32'd0);
    chk("rst_i_ready_n", 32'(bus.i_ready_n), 32'd1);
    chk("rst_d_ready_n", 32'(bus.d_ready_n), 32'd1);
    chk("rst_d_busy", 32'(bus.d_busy), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_i_rdata", bus.i_rdata, 32'd0);
    chk("rst_d_rdata", bus.d_rdata, 32'd0);
    tick();

    // fetch only, 1-cycle memory
    mem_lat = 1; mem_data = 32'h0000_0013; b0 = bursts;
    bus.i_addr = 32'h0000_0100; bus.i_req = 1'b1;
    ok = 1'b0; cyc = 0; s_addr = '0; s_size = '0; s_wr = 1'b1;
    while (!ok && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (bus.m_req) begin s_addr = bus.m_addr; s_size = bus.m_size; s_wr = bus.m_write; end
      if (!bus.i_ready_n) ok = 1'b1;
    end
    chk("t1_done", 32'(ok), 32'd1);
    chk("t1_latency", 32'(cyc), 32'd3);
    chk("t1_i_rdata", bus.i_rdata, 32'h0000_0013);
    chk("t1_m_addr", s_addr, 32'h0000_0100);
    chk("t1_m_size", 32'(s_size), 32'd2);
    chk("t1_m_write", 32'(s_wr), 32'd0);
    tick();
    bus.i_req = 1'b0;
    tick(); tick();
    chk("t1_bursts", 32'(bursts - b0), 32'd1);

    // simultaneous load and fetch: data first, then fetch
    mem_lat = 2; mem_data = 32'hDEAD_BEEF; glog.delete();
    bus.i_addr = 32'h0000_0104; bus.i_req = 1'b1;
    bus.d_addr = 32'h0000_2000; bus.d_write = 1'b0; bus.d_size = 2'b10; bus.d_req = 1'b1;
    wait_rdy(1'b1, 10, cyc, ok);
    chk("t2_d_done", 32'(ok), 32'd1);
    chk("t2_d_rdata", bus.d_rdata, 32'hDEAD_BEEF);
    chk("t2_i_not_ready", 32'(bus.i_ready_n), 32'd1);
    tick();
    bus.d_req = 1'b0; mem_data = 32'h0000_0093;
    ok = 1'b0; cyc = 0; busy_seen = 1'b0;
    while (!ok && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (bus.m_req && bus.d_busy) busy_seen = 1'b1;
      if (!bus.i_ready_n) ok = 1'b1;
    end
    chk("t2_i_done", 32'(ok), 32'd1);
    chk("t2_i_rdata", bus.i_rdata, 32'h0000_0093);
    chk("t2_busy_in_iacc", 32'(busy_seen), 32'd1);
    chk("t2_busy_in_resp", 32'(bus.d_busy), 32'd1);
    chk("t2_grants", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) begin
      chk("t2_first_data", 32'(glog[0]), 32'd2);
      chk("t2_then_fetch", 32'(glog[1]), 32'd1);
    end
    tick();
    bus.i_req = 1'b0;
    tick();

    // byte store: request latched at grant, d_rdata untouched
    mem_lat = 3; mem_data = 32'h1234_5678;
    bus.d_write = 1'b1; bus.d_size = 2'b00; bus.d_wdata = 32'h0000_0055;
    bus.d_addr = 32'h0000_3003; bus.d_req = 1'b1;
    tick();
    bus.d_wdata = 32'h0000_0099; bus.d_addr = 32'h0000_7777;
    ok = 1'b0; cyc = 0; acc = 0; stable_ok = 1'b1;
    while (!ok && cyc < 12) begin
      @(negedge clk);
      cyc++;
      if (bus.m_req) begin
        acc++;
        if (bus.m_wdata != 32'h55 || bus.m_write != 1'b1 || bus.m_size != 2'b00 || bus.m_addr != 32'h3003)
          stable_ok = 1'b0;
      end
      if (!bus.d_ready_n) ok = 1'b1;
    end
    chk("t3_done", 32'(ok), 32'd1);
    chk("t3_stable", 32'(stable_ok), 32'd1);
    chk("t3_acc_cycles", 32'(acc), 32'd3);
    chk("t3_d_rdata_kept", bus.d_rdata, 32'hDEAD_BEEF);
    tick();
    bus.d_req = 1'b0; bus.d_write = 1'b0;
    tick();

    // timeout on a dead memory, then retry succeeds
    mem_hang = 1'b1; mem_lat = 1; mem_data = 32'hCAFE_F00D;
    bus.d_addr = 32'h0000_4000; bus.d_size = 2'b10; bus.d_req = 1'b1;
    ok = 1'b0; cyc = 0; acc = 0;
    while (!ok && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus.m_req) acc++;
      if (bus.err) ok = 1'b1;
    end
    chk("t4_err_seen", 32'(ok), 32'd1);
    chk("t4_acc_cycles", 32'(acc), 32'd4);
    chk("t4_m_req_dropped", 32'(bus.m_req), 32'd0);
    chk("t4_no_ready", 32'(bus.d_ready_n), 32'd1);
    mem_hang = 1'b0;
    wait_rdy(1'b1, 10, cyc, ok);
    chk("t4_retry_done", 32'(ok), 32'd1);
    chk("t4_retry_latency", 32'(cyc), 32'd2);
    chk("t4_retry_rdata", bus.d_rdata, 32'hCAFE_F00D);
    tick();
    bus.d_req = 1'b0;
    tick();

    // stray m_ready_n while idle is ignored
    mem_stray = 1'b1;
    tick();
    mem_stray = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("t5_i_ready_n", 32'(bus.i_ready_n), 32'd1);
      chk("t5_d_ready_n", 32'(bus.d_ready_n), 32'd1);
    end
    tick();

    // reset during a data access
    mem_hang = 1'b1; mem_data = 32'h600D_600D;
    bus.d_addr = 32'h0000_5000; bus.d_write = 1'b0; bus.d_req = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("t6_in_access", 32'(bus.m_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_drop", 32'(bus.m_req), 32'd0);
    chk("t6_no_ready", 32'(bus.d_ready_n), 32'd1);
    mem_hang = 1'b0;
    @(negedge clk);
    chk("t6_no_ready_in_rst", 32'(bus.d_ready_n), 32'd1);
    #2 rst_n = 1'b1;
    wait_rdy(1'b1, 10, cyc, ok);
    chk("t6_served", 32'(ok), 32'd1);
    chk("t6_rdata", bus.d_rdata, 32'h600D_600D);
    tick();
    bus.d_req = 1'b0;
    tick();

    // both requests held: grant order depends on fairness
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    mem_lat = 1; mem_data = 32'h0000_0001; glog.delete();
    bus.i_addr = 32'h0000_0200; bus.i_req = 1'b1;
    bus.d_addr = 32'h0000_8000; bus.d_write = 1'b0; bus.d_req = 1'b1;
    ok = 1'b0; cyc = 0;
    while (!ok && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (glog.size() >= 6 && (!bus.d_ready_n || !bus.i_ready_n)) ok = 1'b1;
    end
    tick();
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    if (FAIR) exp_order = '{2, 2, 2, 2, 1, 2};
    else      exp_order = '{2, 2, 2, 2, 2, 2};
    chk("t7_done", 32'(ok), 32'd1);
    chk("t7_grants", 32'(glog.size()), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < glog.size()) chk($sformatf("t7_grant%0d", k), 32'(glog[k]), 32'(exp_order[k]));
    end
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
